// File: rtl/fault_pkg.sv
// rtl/fault_pkg.sv - shared types and constants for the stuck-at fault pattern generator
package fault_pkg;

  localparam int VEC_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    COMPARE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    LOC_A = 2'd0,
    LOC_B = 2'd1,
    LOC_C = 2'd2,
    LOC_D = 2'd3
  } loc_t;

  localparam logic SA0 = 1'b0;
  localparam logic SA1 = 1'b1;

  // Site A is the MSB of the vector, so the bit index runs opposite to the location code.
  function automatic logic [1:0] loc_bit(input logic [1:0] loc);
    return 2'd3 - loc;
  endfunction

endpackage

// File: rtl/fault_inject.sv
// rtl/fault_inject.sv - forces the selected vector bit to the stuck-at value
module fault_inject
  import fault_pkg::*;
(
  input  logic [VEC_W-1:0] vec_good,
  input  logic [1:0]       fault_loc,
  input  logic             fault_type,
  output logic [VEC_W-1:0] vec_fault
);

  always_comb begin
    vec_fault = vec_good;
    vec_fault[loc_bit(fault_loc)] = (fault_type == SA1) ? 1'b1 : 1'b0;
  end

endmodule

// File: rtl/fault_pattern_gen.sv
// rtl/fault_pattern_gen.sv - exhaustive 4-input stuck-at fault test sequencer
// FAULT_ALL_VEC_EN: sweep all 16 vectors and count detections; otherwise stop on first detection.
module fault_pattern_gen
  import fault_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       fault_loc,
  input  logic             fault_type,
  output logic [VEC_W-1:0] vec_good,
  output logic [VEC_W-1:0] vec_fault,
  input  logic             z_good,
  input  logic             z_fault,
  output logic             busy,
  output logic             done,
  output logic             detected,
  output logic [VEC_W-1:0] first_vec
`ifdef FAULT_ALL_VEC_EN
  ,
  output logic [4:0]       det_count
`endif
);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] cnt, cnt_nxt;
  logic [3:0]       settle_cnt, settle_cnt_nxt;
  loc_t             loc_q, loc_nxt;
  logic             type_q, type_nxt;
  logic             detected_nxt;
  logic [VEC_W-1:0] first_vec_nxt;
  logic [VEC_W-1:0] inj_vec;
  logic             driving;
  logic             mismatch;
  logic             finish;
`ifdef FAULT_ALL_VEC_EN
  logic [4:0]       det_count_nxt;
`endif

  fault_inject u_inject (
    .vec_good  (cnt),
    .fault_loc (loc_q),
    .fault_type(type_q),
    .vec_fault (inj_vec)
  );

  // Vectors are held from APPLY through COMPARE and are zero everywhere else.
  assign driving   = (state == APPLY) || (state == SETTLE) || (state == COMPARE);
  assign vec_good  = driving ? cnt : '0;
  assign vec_fault = driving ? inj_vec : '0;
  assign mismatch  = z_good ^ z_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      settle_cnt <= '0;
      loc_q      <= LOC_A;
      type_q     <= SA0;
      detected   <= 1'b0;
      first_vec  <= '0;
`ifdef FAULT_ALL_VEC_EN
      det_count  <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      settle_cnt <= settle_cnt_nxt;
      loc_q      <= loc_nxt;
      type_q     <= type_nxt;
      detected   <= detected_nxt;
      first_vec  <= first_vec_nxt;
`ifdef FAULT_ALL_VEC_EN
      det_count  <= det_count_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    settle_cnt_nxt = settle_cnt;
    loc_nxt        = loc_q;
    type_nxt       = type_q;
    detected_nxt   = detected;
    first_vec_nxt  = first_vec;
`ifdef FAULT_ALL_VEC_EN
    det_count_nxt  = det_count;
    finish         = (cnt == 4'd15);
`else
    finish         = (cnt == 4'd15) || mismatch;
`endif
    busy           = (state != IDLE);
    done           = (state == DONE);

    case (state)
      IDLE: begin
        if (start) begin
          loc_nxt       = loc_t'(fault_loc);
          type_nxt      = fault_type;
          cnt_nxt       = '0;
          detected_nxt  = 1'b0;
          first_vec_nxt = '0;
`ifdef FAULT_ALL_VEC_EN
          det_count_nxt = '0;
`endif
          state_nxt     = APPLY;
        end
      end
      APPLY: begin
        settle_cnt_nxt = '0;
        state_nxt      = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == 4'(SETTLE_CYC - 1)) begin
          state_nxt = COMPARE;
        end else begin
          settle_cnt_nxt = settle_cnt + 4'd1;
        end
      end
      COMPARE: begin
        if (mismatch && !detected) begin
          detected_nxt  = 1'b1;
          first_vec_nxt = cnt;
        end
`ifdef FAULT_ALL_VEC_EN
        if (mismatch) begin
          det_count_nxt = det_count + 5'd1;
        end
`endif
        if (finish) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt + 4'd1;
          state_nxt = APPLY;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/fault_pattern_gen.md
FAULT_PATTERN_GEN -- requirements
Module: fault_pattern_gen

Interface
REQ-001 SETTLE_CYC, default 2, meaning: wait cycles between applying a vector and sampling the responses (legal range 1..15).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a fault test; sampled only in IDLE.
REQ-005 fault_loc  input  2  fault site: 0=A, 1=B, 2=C, 3=D.
REQ-006 fault_type  input  1  fault polarity: 0=SA0, 1=SA1.
REQ-007 vec_good  output  4  drive to the fault-free circuit copy: bit3=A, bit2=B, bit1=C, bit0=D.
REQ-008 vec_fault  output  4  drive to the faulty circuit copy: vec_good with the selected bit forced to fault_type.
REQ-009 z_good  input  1  Z from the fault-free copy.
REQ-010 z_fault  input  1  Z from the faulty copy.
REQ-011 busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-012 done  output  1  one-cycle pulse at the end of a test.
REQ-013 detected  output  1  at least one vector exposed the fault; held until the next accepted start.
REQ-014 first_vec  output  4  index of the first detecting vector; 0 when not detected.
REQ-015 det_count  output  5  number of detecting vectors, 0..16; present only with FAULT_ALL_VEC_EN.

Function
REQ-016 The FSM SHALL use the states IDLE, APPLY, SETTLE, COMPARE and DONE.
REQ-017 IDLE with start=1: latch fault_loc/fault_type, clear the vector counter, detected, first_vec and det_count, and go to APPLY.
REQ-018 APPLY (1 cycle): drive vec_good = counter; drive vec_fault = counter with bit (3-fault_loc) replaced by fault_type; go to SETTLE.
REQ-019 SETTLE: hold vectors for exactly SETTLE_CYC cycles, then go to COMPARE.
REQ-020 COMPARE (1 cycle): mismatch = z_good XOR z_fault; on the first mismatch set detected=1 and first_vec=counter.
REQ-021 Each vector SHALL therefore take exactly 2+SETTLE_CYC cycles.
REQ-022 After COMPARE: if the counter is 15, or (stop-on-first mode and a mismatch occurred), go to DONE; otherwise increment the counter and go to APPLY.
REQ-023 DONE (1 cycle): done=1, then go to IDLE; vec_good and vec_fault return to 0 in IDLE.
REQ-024 start while busy or in DONE SHALL be ignored; latched fault_loc/fault_type SHALL NOT change during a test.
REQ-025 The counter SHALL NOT wrap: vector 15 always ends the sweep.
REQ-026 When the faulty site already equals fault_type, vec_fault equals vec_good and no mismatch is expected; no special handling.

Reset
REQ-027 rst=1 at any time, including mid-test, SHALL immediately force IDLE with the counter, vec_good, vec_fault, busy, done, detected, first_vec and det_count all 0.
REQ-028 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro FAULT_ALL_VEC_EN defined: always sweep all 16 vectors; det_count increments on every mismatch; first_vec still records the first mismatch.
REQ-030 FAULT_ALL_VEC_EN undefined: stop-on-first mode; the det_count port and its logic are absent.

Structure
REQ-031 A shared package fault_pkg SHALL hold the FSM state enum, the fault_loc encodings (LOC_A..LOC_D), SA0/SA1 constants and the vector width constant 4.
REQ-032 One sub-module fault_inject SHALL be used: combinational vec_good, fault_loc and fault_type to vec_fault.

Verification (bench models Z = (A&B)|(C&D) for both copies, SETTLE_CYC=2)
REQ-033 B SA1, stop mode -> detected=1, first_vec=8, done 9*4 cycles after busy rises.
REQ-034 B SA1, FAULT_ALL_VEC_EN -> detected=1, first_vec=8, det_count=3 (vectors 8, 9, 10), done after 64 cycles.
REQ-035 D SA0, FAULT_ALL_VEC_EN -> first_vec=3, det_count=3 (vectors 3, 7, 11).
REQ-036 Faulty copy tied equal to the good copy -> detected=0, first_vec=0, det_count=0, done after 64 cycles.
REQ-037 rst pulsed during SETTLE of vector 5 -> all outputs 0 and IDLE next edge; a new start then runs a normal test from vector 0.
REQ-038 start re-pulsed while busy -> ignored; results identical to an undisturbed run.
